median_window_feeder: RTL and testbench
=======================================

// Module: median_window_feeder
// PURPOSE
//  Producer side of the median filter's sample interface. Takes a raster pixel stream and builds a 3x3 neighbourhood
//  from two line buffers. For every interior pixel it sends the 9 window samples serially, one per handshake,
//  to median_sorting. Sits between the camera/frame source and the median filter.
// PARAMETERS
//  S      8   pixel width in bits
//  IMG_W  64  pixels per line (>=3)
//  IMG_H  48  lines per frame (>=3)
// PORTS
//  clk        in   1  single clock, rising edge
//  reset      in   1  asynchronous, active-low reset
//  pix_valid  in   1  input pixel present
//  pix_in     in   S  input pixel, raster order
//  pix_ready  out  1  feeder accepts pixel (pix_valid&&pix_ready = accept)
//  out_valid  out  1  window sample present
//  out_data   out  S  window sample
//  out_last   out  1  high with 9th sample of a window
//  out_ready  in   1  filter takes sample (out_valid&&out_ready = transfer)
// BEHAVIOUR
//  - Reset (reset=0, async): state=FILL, x=0, y=0, idx=0, window regs=0, out_valid=0, out_data=0, out_last=0,
//    pix_ready=1. Line-buffer contents are not reset; they are only read once two lines are written.
//  - FSM, 2 states:
//    FILL: pix_ready=1, out_valid=0. On accept at (x,y):
//    - Form column: top=lb1[x], mid=lb0[x], bot=pix_in.
//    - Shift window left by one column; the new column enters at right.
//    - Write lb1[x]<=lb0[x] and lb0[x]<=pix_in. Reads happen before writes (async-read regs).
//    - If x>=2 && y>=2, go to EMIT with idx=0; else stay in FILL.
//    EMIT: pix_ready=0, out_valid=1, out_data=win[idx], out_last=(idx==8). Each transfer does idx++.
//    - A transfer at idx==8 returns to FILL with idx=0.
//    - While out_ready=0, out_data and out_last hold stable.
//  - Sample order is row-major, oldest row first:
//    win[0..2]=(y-2,x-2..x), win[3..5]=(y-1,..), win[6..8]=(y,..).
//  - Latency: pixel accepted at cycle t -> out_valid=1 with win[0] at t+1. Best case 10 cycles per interior pixel.
//  - Counters:
//    - x wraps IMG_W-1 -> 0 with y++.
//    - At x==IMG_W-1 && y==IMG_H-1, both wrap to 0 (frame end).
//    - The window is not cleared at a line change; windows are emitted only at x>=2, so stale columns never go out.
//  - Border pixels (x<2 or y<2) produce no output. Each frame emits (IMG_W-2)*(IMG_H-2) windows.
//  - Reset mid-EMIT aborts the window immediately. No partial completion; out_last is never asserted.
//  - Widths: x is clog2(IMG_W) bits, y is clog2(IMG_H) bits, idx is 4 bits. Data is passed through, no arithmetic.
// CONFIGURATION
//  MEDIAN_FEEDER_SOF_EN:
//  - Defined: adds input sof (1 bit). An accept with sof=1 forces this pixel to be (0,0) and restarts x/y counting.
//    Effect on the 3x3 window registers:
//    - Pixel forced to (0,0): no window is emitted.
//    - sof=1 during EMIT: ignored, because no accept happens.
//  - Undefined: no sof port; frame position comes only from the counters.
// STRUCTURE
//  - Package median_pkg:
//    - S default, N_WIN=9.
//    - typedef enum {FILL, EMIT} feeder_state_t.
//    - Shared with median_sorting.
//  - Sub-module median_line_buffer:
//    - IMG_W x S register array; async read, sync write.
//    - Instantiated twice (lb0, lb1).
// TESTING (IMG_W=4, IMG_H=4, pixel(x,y)=4y+x+1, out_ready=1 unless stated)
//  1 Reset, stream 16 pixels -> first out_valid the cycle after pixel 11 is accepted.
//    - Samples 1,2,3,5,6,7,9,10,11, out_last on 11.
//    - 4 windows total; centres 6,7,10,11.
//  2 Backpressure: out_ready=0 for 5 cycles at idx=4 -> out_data=6 held and pix_ready=0 throughout. Resume gives 7,9,10,11.
//  3 Second frame streamed back-to-back -> its first window is again 1,2,3,5,6,7,9,10,11; no window at frame seam.
//  4 Reset low at idx=3 of first window:
//    - out_valid=0 asynchronously; no out_last.
//    - After release, restream the frame -> the full 4-window result of test 1.
//  5 pix_valid gaps, random 0-3 idle cycles between pixels -> same sample sequence as test 1.
//  6 (SOF_EN) Assert sof on pixel 6 of frame 1, then stream 16 pixels -> position restarts at that pixel.
//    - First emitted window follows test 1's pattern relative to that pixel.

Source files
------------

// File: rtl/median_pkg.sv
// Shared types and constants for the median filter datapath (feeder and sorter).
package median_pkg;

    localparam int unsigned S_DEFAULT = 8;
    localparam int unsigned N_WIN     = 9;
    localparam int unsigned IDX_W     = 4;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        EMIT = 1'b1
    } feeder_state_t;

endpackage

// File: rtl/median_line_buffer.sv
// One raster line of pixel storage: combinational read, registered write at the same address.
module median_line_buffer
    import median_pkg::*;
#(
    parameter int unsigned S     = S_DEFAULT,
    parameter int unsigned DEPTH = 64,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  logic [S-1:0]  wr_data,
    output logic [S-1:0]  rd_data_c
);

    logic [S-1:0] mem [DEPTH];

    // Read returns the old contents in the write cycle, so a line can shift into the next buffer.
    assign rd_data_c = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/median_window_feeder.sv
// Builds a 3x3 window from a raster stream and emits its 9 samples serially, oldest row first.
// Optional MEDIAN_FEEDER_SOF_EN adds a sof input that forces the accepted pixel to position (0,0).
module median_window_feeder
    import median_pkg::*;
#(
    parameter int unsigned S     = S_DEFAULT,
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 48
) (
    input  logic         clk,
    input  logic         reset,
`ifdef MEDIAN_FEEDER_SOF_EN
    input  logic         sof,
`endif
    input  logic         pix_valid,
    input  logic [S-1:0] pix_in,
    output logic         pix_ready,
    output logic         out_valid,
    output logic [S-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready
);

    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);

    feeder_state_t  state, state_nx;
    logic [XW-1:0]  x, x_nx, x_cur_c;
    logic [YW-1:0]  y, y_nx, y_cur_c;
    logic [IDX_W-1:0] idx, idx_nx;
    logic [S-1:0]   win    [N_WIN];
    logic [S-1:0]   win_nx [N_WIN];
    logic           pix_ready_nx, out_valid_nx, out_last_nx;
    logic [S-1:0]   out_data_nx;
    logic [S-1:0]   lb0_rd_c, lb1_rd_c;
    logic           accept_c, xfer_c;

    assign accept_c = pix_valid && pix_ready;
    assign xfer_c   = out_valid && out_ready;

    // Position of the pixel being offered; sof restarts the frame at this pixel.
    always_comb begin
        x_cur_c = x;
        y_cur_c = y;
`ifdef MEDIAN_FEEDER_SOF_EN
        if (sof) begin
            x_cur_c = '0;
            y_cur_c = '0;
        end
`endif
    end

    // lb0 holds line y-1, lb1 holds line y-2 at each column.
    median_line_buffer #(.S(S), .DEPTH(IMG_W)) lb0 (
        .clk       (clk),
        .wr_en     (accept_c),
        .addr      (x_cur_c),
        .wr_data   (pix_in),
        .rd_data_c (lb0_rd_c)
    );

    median_line_buffer #(.S(S), .DEPTH(IMG_W)) lb1 (
        .clk       (clk),
        .wr_en     (accept_c),
        .addr      (x_cur_c),
        .wr_data   (lb0_rd_c),
        .rd_data_c (lb1_rd_c)
    );

    always_comb begin
        state_nx     = state;
        x_nx         = x;
        y_nx         = y;
        idx_nx       = idx;
        win_nx       = win;
        pix_ready_nx = pix_ready;
        out_valid_nx = out_valid;
        out_data_nx  = out_data;
        out_last_nx  = out_last;

        case (state)
            FILL: begin
                if (accept_c) begin
                    // Shift window left; new column (y-2, y-1, y) enters at the right.
                    for (int r = 0; r < 3; r++) begin
                        win_nx[3*r]     = win[3*r + 1];
                        win_nx[3*r + 1] = win[3*r + 2];
                    end
                    win_nx[2] = lb1_rd_c;
                    win_nx[5] = lb0_rd_c;
                    win_nx[8] = pix_in;

                    if (x_cur_c == XW'(IMG_W - 1)) begin
                        x_nx = '0;
                        y_nx = (y_cur_c == YW'(IMG_H - 1)) ? '0 : y_cur_c + YW'(1);
                    end else begin
                        x_nx = x_cur_c + XW'(1);
                        y_nx = y_cur_c;
                    end

                    if (x_cur_c >= XW'(2) && y_cur_c >= YW'(2)) begin
                        state_nx     = EMIT;
                        idx_nx       = '0;
                        pix_ready_nx = 1'b0;
                        out_valid_nx = 1'b1;
                        out_data_nx  = win_nx[0];
                        out_last_nx  = 1'b0;
                    end
                end
            end
            EMIT: begin
                if (xfer_c) begin
                    if (idx == IDX_W'(N_WIN - 1)) begin
                        state_nx     = FILL;
                        idx_nx       = '0;
                        pix_ready_nx = 1'b1;
                        out_valid_nx = 1'b0;
                        out_last_nx  = 1'b0;
                    end else begin
                        idx_nx      = idx + IDX_W'(1);
                        out_data_nx = win[idx_nx];
                        out_last_nx = (idx_nx == IDX_W'(N_WIN - 1));
                    end
                end
            end
            default: begin
                state_nx = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FILL;
            x         <= '0;
            y         <= '0;
            idx       <= '0;
            for (int i = 0; i < N_WIN; i++) begin
                win[i] <= '0;
            end
            pix_ready <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nx;
            x         <= x_nx;
            y         <= y_nx;
            idx       <= idx_nx;
            win       <= win_nx;
            pix_ready <= pix_ready_nx;
            out_valid <= out_valid_nx;
            out_data  <= out_data_nx;
            out_last  <= out_last_nx;
        end
    end

endmodule

// File: tb/tb_median_window_feeder.sv
// Self-checking bench for median_window_feeder on a 4x4 image with pixel(x,y)=4y+x+1.
module tb_median_window_feeder;

    localparam int unsigned S     = 8;
    localparam int unsigned IMG_W = 4;
    localparam int unsigned IMG_H = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         pix_valid = 1'b0;
    logic [S-1:0] pix_in = '0;
    logic         pix_ready;
    logic         out_valid;
    logic [S-1:0] out_data;
    logic         out_last;
    logic         out_ready = 1'b1;
`ifdef MEDIAN_FEEDER_SOF_EN
    logic         sof = 1'b0;
`endif

    always #5 clk = ~clk;

    median_window_feeder #(.S(S), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef MEDIAN_FEEDER_SOF_EN
        .sof       (sof),
`endif
        .pix_valid (pix_valid),
        .pix_in    (pix_in),
        .pix_ready (pix_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [S-1:0] data;
        logic         last;
    } smp_t;

    typedef struct {
        logic [S-1:0] pix;
        logic         emits;
    } pix_vec_t;

    smp_t     exp_q[$];
    smp_t     mon_e;
    smp_t     win_tbl [36];
    pix_vec_t frame_tbl [16];
    int       vectors = 0;
    int       miscompares = 0;
    int       xfer_cnt = 0;
    int       last_cnt = 0;

    // Scoreboard: every accepted output sample is popped and compared.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_sample got data=%0d last=%0b required none", out_data, out_last);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_data !== mon_e.data || out_last !== mon_e.last) begin
                    miscompares++;
                    $display("FAIL sample got data=%0d last=%0b required data=%0d last=%0b",
                             out_data, out_last, mon_e.data, mon_e.last);
                end
            end
            xfer_cnt++;
            if (out_last) last_cnt++;
        end
    end

    task automatic check(input string name, input int got, input int req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic push_frame(input int add);
        smp_t e;
        for (int i = 0; i < 36; i++) begin
            e.data = win_tbl[i].data + S'(add);
            e.last = win_tbl[i].last;
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input logic [S-1:0] p);
        int  n = 0;
        logic acc = 1'b0;
        pix_valid = 1'b1;
        pix_in    = p;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = pix_ready;
            @(posedge clk);
            #1;
            n++;
        end
        pix_valid = 1'b0;
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_xfer(input int target);
        int n = 0;
        while (xfer_cnt < target && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (xfer_cnt < target) check("xfer_timeout", xfer_cnt, target);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic stream_frame(input int add);
        for (int i = 0; i < 16; i++) send(frame_tbl[i].pix + S'(add));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle(3);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_out_last", 32'(out_last), 0);
        check("reset_out_data", 32'(out_data), 0);
        check("reset_pix_ready", 32'(pix_ready), 1);
        reset = 1'b1;
        idle(1);
    endtask

    initial begin
        int centres [4] = '{6, 7, 10, 11};
        int offs    [9] = '{-5, -4, -3, -1, 0, 1, 3, 4, 5};
        bit emit_bits [16] = '{0,0,0,0, 0,0,0,0, 0,0,1,1, 0,0,1,1};
        int base;

        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 9; k++) begin
                win_tbl[w*9 + k].data = S'(centres[w] + offs[k]);
                win_tbl[w*9 + k].last = (k == 8);
            end
        end
        for (int i = 0; i < 16; i++) begin
            frame_tbl[i].pix   = S'(i + 1);
            frame_tbl[i].emits = emit_bits[i];
        end

        // 1: basic frame, latency of first out_valid per accepted pixel
        do_reset();
        push_frame(0);
        base = last_cnt;
        for (int i = 0; i < 16; i++) begin
            send(frame_tbl[i].pix);
            check("t1_valid_after_accept", 32'(out_valid), 32'(frame_tbl[i].emits));
        end
        drain("t1_drain");
        check("t1_windows", last_cnt - base, 4);

        // 2: backpressure at idx 4 of the first window
        push_frame(0);
        base = last_cnt;
        fork
            stream_frame(0);
            begin
                wait_xfer(xfer_cnt + 4);
                out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check("t2_hold_data", 32'(out_data), 6);
                    check("t2_hold_valid", 32'(out_valid), 1);
                    check("t2_pix_ready_low", 32'(pix_ready), 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("t2_drain");
        check("t2_windows", last_cnt - base, 4);

        // 3: two frames back to back, nothing across the seam
        push_frame(0);
        push_frame(0);
        base = last_cnt;
        stream_frame(0);
        stream_frame(0);
        drain("t3_drain");
        check("t3_windows", last_cnt - base, 8);

        // 4: reset asserted at idx 3 of the first window
        push_frame(0);
        base = xfer_cnt;
        for (int i = 0; i < 11; i++) send(frame_tbl[i].pix);
        wait_xfer(base + 3);
        reset = 1'b0;
        #1;
        check("t4_async_valid", 32'(out_valid), 0);
        check("t4_async_last", 32'(out_last), 0);
        exp_q.delete();
        idle(2);
        check("t4_last_in_reset", 32'(out_last), 0);
        reset = 1'b1;
        idle(1);
        push_frame(0);
        base = last_cnt;
        stream_frame(0);
        drain("t4_drain");
        check("t4_windows", last_cnt - base, 4);

        // 5: random idle gaps between pixels
        push_frame(0);
        base = last_cnt;
        for (int i = 0; i < 16; i++) begin
            idle($urandom_range(0, 3));
            send(frame_tbl[i].pix);
        end
        drain("t5_drain");
        check("t5_windows", last_cnt - base, 4);

`ifdef MEDIAN_FEEDER_SOF_EN
        // 6: sof on pixel 6 restarts the frame position there
        do_reset();
        push_frame(5);
        base = last_cnt;
        for (int i = 0; i < 5; i++) send(frame_tbl[i].pix);
        sof = 1'b1;
        send(S'(6));
        sof = 1'b0;
        for (int i = 1; i < 16; i++) send(frame_tbl[i].pix + S'(5));
        drain("t6_drain");
        check("t6_windows", last_cnt - base, 4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
